// File: rtl/apb_pkg.sv
// Shared types and constants for the APB arbitrating master.
//   apb_mst_state_t : master sequencing states (IDLE, SETUP, ACCESS, RESP)
//   APB_OKAY/APB_ERR: values carried on the response error flag
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_mst_state_t;

  localparam logic APB_OKAY = 1'b0;
  localparam logic APB_ERR  = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
// Scans req starting one past 'last' and wrapping; reports the first set bit.
// Ports:
//   req    in  N   request vector
//   last   in  IW  index of the previous winner (scan starts at last+1)
//   valid  out 1   any request present
//   winner out IW  selected index (equals 'last' when no request)
// The pointer register lives in the parent.
module rr_arbiter #(
  parameter int unsigned N = 2,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          valid,
  output logic [IW-1:0] winner
);

  always_comb begin
    int unsigned idx;
    logic [IW-1:0] cand;
    idx    = 0;
    cand   = '0;
    valid  = 1'b0;
    winner = last;
    // Offsets 1..N visit every requester once, 'last' itself coming last.
    for (int unsigned off = 1; off <= N; off++) begin
      idx  = (32'(last) + off) % N;
      cand = IW'(idx);
      if (!valid && req[cand]) begin
        valid  = 1'b1;
        winner = cand;
      end
    end
  end

endmodule

// File: rtl/apb_arb_master.sv
// APB master shared by NUM_REQ local requesters.
// Round-robin arbitration in IDLE, then SETUP/ACCESS sequencing toward one
// APB slave, then a one-cycle RESP pulse back to the winner. A PREADY
// timeout (TIMEOUT ACCESS cycles, 0 = off) aborts a hung transfer with error.
// Ports:
//   PCLK, PRESET             clock (rising) / async active-high reset
//   req_valid/write          per-requester request and direction (1=write)
//   req_addr/wdata           flattened payloads, slice i at [i*W +: W]
//   rsp_valid                one-hot completion pulse
//   rsp_rdata, rsp_err       response data / error, held until next completion
//   grant                    current or last granted requester
//   busy                     high in SETUP, ACCESS and RESP
//   PSEL..PWDATA             APB request outputs (all registered)
//   PRDATA, PREADY, PSLVERR  APB response inputs
module apb_arb_master
  import apb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                           PCLK,
  input  logic                           PRESET,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [DATA_WIDTH-1:0]          rsp_rdata,
  output logic                           rsp_err,
  output logic [$clog2(NUM_REQ)-1:0]     grant,
  output logic                           busy,
  output logic                           PSEL,
  output logic                           PENABLE,
  output logic                           PWRITE,
  output logic [ADDR_WIDTH-1:0]          PADDR,
  output logic [DATA_WIDTH-1:0]          PWDATA,
  input  logic [DATA_WIDTH-1:0]          PRDATA,
  input  logic                           PREADY,
  input  logic                           PSLVERR
);

  localparam int unsigned GW = $clog2(NUM_REQ);
  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  apb_mst_state_t        state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [GW-1:0]         last_q, last_d;
  logic [GW-1:0]         grant_q, grant_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  busy_q, busy_d;

  logic                  arb_valid;
  logic [GW-1:0]         arb_winner;
  logic                  sel_write;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  timeout_hit;
  logic                  done;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req    (req_valid),
    .last   (last_q),
    .valid  (arb_valid),
    .winner (arb_winner)
  );

  // Payload mux for the arbitration winner.
  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (arb_winner == GW'(i)) begin
        sel_write = req_write[i];
        sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    grant_d     = grant_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    done        = 1'b0;

    case (state_q)
      IDLE: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        cnt_d     = '0;
        if (arb_valid) begin
          grant_d  = arb_winner;
          last_d   = arb_winner;
          pwrite_d = sel_write;
          paddr_d  = sel_addr;
          pwdata_d = sel_wdata;
          psel_d   = 1'b1;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        // PREADY is tested first so a ready in the timeout cycle completes normally.
        if (PREADY) begin
          rsp_rdata_d = pwrite_q ? '0 : PRDATA;
          rsp_err_d   = PSLVERR;
          done        = 1'b1;
        end else if (timeout_hit) begin
          rsp_rdata_d = '0;
          rsp_err_d   = APB_ERR;
          done        = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        if (done) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          cnt_d     = '0;
          state_d   = RESP;
          for (int unsigned i = 0; i < NUM_REQ; i++) begin
            rsp_valid_d[i] = (grant_q == GW'(i));
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
        cnt_d     = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_q      <= GW'(NUM_REQ - 1);
      grant_q     <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= APB_OKAY;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      grant_q     <= grant_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign grant     = grant_q;
  assign busy      = busy_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;

endmodule

// File: tb/tb_apb_arb_master.sv
// Bench for apb_arb_master: two requesters, TIMEOUT=4, APB slave model with
// programmable wait states, error and hang. Responses are scored against a
// queue of expectations pushed when each request is driven.
module tb_apb_arb_master;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic [1:0]  req_valid, req_write;
  logic [63:0] req_addr, req_wdata;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        grant;
  logic        busy;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PREADY, PSLVERR;

  apb_arb_master #(
    .NUM_REQ(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(4)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .grant(grant), .busy(busy),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  int unsigned cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  // ---------------- slave model ----------------
  int unsigned wait_n = 0;
  bit          hang = 1'b0;
  bit          err_mode = 1'b0;
  int unsigned wcnt = 0;
  logic [31:0] smem [16];
  logic [15:0] swr = '0;

  assign PREADY  = PSEL && PENABLE && !hang && (wcnt == wait_n);
  assign PSLVERR = err_mode;
  assign PRDATA  = swr[PADDR[5:2]] ? smem[PADDR[5:2]] : (32'hA500_0000 | {28'h0, PADDR[5:2]});

  always @(posedge PCLK) begin
    if (PSEL && PENABLE && !PREADY) wcnt <= wcnt + 1;
    else                            wcnt <= 0;
    if (PSEL && PENABLE && PREADY && PWRITE) begin
      smem[PADDR[5:2]] <= PWDATA;
      swr[PADDR[5:2]]  <= 1'b1;
    end
  end

  // ---------------- expected-memory model ----------------
  logic [31:0] emem [16];
  bit   [15:0] ewr = '0;

  function automatic logic [31:0] exp_rd(input logic [31:0] a);
    logic [3:0] k;
    k = a[5:2];
    return ewr[k] ? emem[k] : (32'hA500_0000 | {28'h0, k});
  endfunction

  // ---------------- scoreboard / checking ----------------
  typedef struct {
    int unsigned idx;
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge PCLK) begin : mon
    exp_t e;
    if (PRESET === 1'b0 && rsp_valid !== 2'b00) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 64'(rsp_valid), 64'd0);
      end else begin
        e = sb.pop_front();
        chk("rsp_valid", 64'(rsp_valid), 64'(2'b01 << e.idx));
        chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
        chk("rsp_err",   64'(rsp_err),   64'(e.err));
      end
    end
  end

  // Single transfer from requester i; reports ACCESS cycle count and the
  // negedge index (from the request) of first PSEL, first PENABLE, and rsp.
  task automatic xfer(input int unsigned i, input bit wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input bit exp_err, input bit abort,
                      output int acc, output int ps_at, output int pe_at, output int rsp_at);
    exp_t e;
    int   bad;
    bit   got;
    req_write[i]          = wr;
    req_addr[i*32 +: 32]  = addr;
    req_wdata[i*32 +: 32] = wdata;
    e.idx   = i;
    e.err   = exp_err;
    e.rdata = (abort || wr) ? 32'h0 : exp_rd(addr);
    if (wr && !abort) begin
      emem[addr[5:2]] = wdata;
      ewr[addr[5:2]]  = 1'b1;
    end
    sb.push_back(e);
    req_valid[i] = 1'b1;
    acc = 0; ps_at = 0; pe_at = 0; rsp_at = 0; bad = 0; got = 1'b0;
    for (int c = 1; c <= 40 && !got; c++) begin
      @(negedge PCLK);
      if (PSEL && ps_at == 0) ps_at = c;
      if (PENABLE && pe_at == 0) pe_at = c;
      if (PSEL && PENABLE) begin
        acc++;
        if (PADDR !== addr) bad++;
      end
      if (rsp_valid[i]) begin
        got = 1'b1;
        rsp_at = c;
      end
    end
    chk("rsp_seen", 64'(got), 64'd1);
    chk("paddr_stable", 64'(bad), 64'd0);
    req_valid[i] = 1'b0;
  endtask

  // Both requesters read concurrently; grants must alternate starting at 0,
  // one completion every 4 cycles.
  task automatic contend(input int n);
    exp_t        e;
    bit          got;
    int unsigned prev;
    req_write = 2'b00;
    req_addr  = {32'h20, 32'h10};
    req_valid = 2'b11;
    for (int k = 0; k < n; k++) begin
      e.idx   = k % 2;
      e.rdata = exp_rd((k % 2) ? 32'h20 : 32'h10);
      e.err   = 1'b0;
      sb.push_back(e);
    end
    prev = 0;
    for (int k = 0; k < n; k++) begin
      got = 1'b0;
      for (int c = 0; c < 40 && !got; c++) begin
        @(negedge PCLK);
        if (rsp_valid !== 2'b00) got = 1'b1;
      end
      chk("contend_rsp_seen", 64'(got), 64'd1);
      chk("contend_grant", 64'(grant), 64'(k % 2));
      if (k > 0) chk("contend_period", 64'(cyc - prev), 64'd4);
      prev = cyc;
      if (k == n - 2) req_valid[0] = 1'b0;
      if (k == n - 1) req_valid[1] = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, ps, pe, ra;
    bit seen;
    PRESET    = 1'b1;
    req_valid = 2'b00;
    req_write = 2'b00;
    req_addr  = {32'h20, 32'h10};
    req_wdata = '0;
    req_valid = 2'b11;
    repeat (2) @(negedge PCLK);

    // reset state
    chk("rst_psel",      64'(PSEL), 64'd0);
    chk("rst_penable",   64'(PENABLE), 64'd0);
    chk("rst_busy",      64'(busy), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    chk("rst_grant",     64'(grant), 64'd0);
    chk("rst_paddr",     64'(PADDR), 64'd0);

    // contention with both requests held from reset
    PRESET = 1'b0;
    contend(4);
    @(negedge PCLK);

    // write, zero wait states: cycle-accurate phases
    xfer(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b0, acc, ps, pe, ra);
    chk("wr_psel_cycle",   64'(ps), 64'd1);
    chk("wr_pen_cycle",    64'(pe), 64'd2);
    chk("wr_rsp_cycle",    64'(ra), 64'd3);
    chk("wr_access_len",   64'(acc), 64'd1);
    chk("wr_slave_reg",    64'(smem[4]), 64'hDEAD_BEEF);
    @(negedge PCLK);
    chk("wr_idle_busy",    64'(busy), 64'd0);
    chk("wr_idle_psel",    64'(PSEL), 64'd0);
    chk("wr_paddr_hold",   64'(PADDR), 64'h10);

    // read with two wait states
    wait_n = 2;
    xfer(1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, acc, ps, pe, ra);
    chk("rd_wait_access_len", 64'(acc), 64'd3);
    wait_n = 0;

    // slave error on a read
    err_mode = 1'b1;
    xfer(0, 1'b0, 32'h20, 32'h0, 1'b1, 1'b0, acc, ps, pe, ra);
    err_mode = 1'b0;
    @(negedge PCLK);
    chk("err_idle_busy", 64'(busy), 64'd0);
    chk("err_hold_rdata", 64'(rsp_rdata), 64'hA500_0008);

    // timeout abort, then PREADY arriving exactly in the timeout cycle
    hang = 1'b1;
    xfer(1, 1'b0, 32'h14, 32'h0, 1'b1, 1'b1, acc, ps, pe, ra);
    chk("to_access_len", 64'(acc), 64'd4);
    hang   = 1'b0;
    wait_n = 3;
    xfer(0, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, acc, ps, pe, ra);
    chk("to_edge_access_len", 64'(acc), 64'd4);
    wait_n = 0;
    @(negedge PCLK);
    chk("hold_rdata", 64'(rsp_rdata), 64'hDEAD_BEEF);
    chk("hold_err",   64'(rsp_err), 64'd0);

    // asynchronous reset during ACCESS; requester 0 is aborted (no score entry)
    hang         = 1'b1;
    req_write[0] = 1'b0;
    req_addr[31:0] = 32'h18;
    req_valid[0] = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge PCLK);
      if (PENABLE) seen = 1'b1;
    end
    chk("rst_mid_access_seen", 64'(seen), 64'd1);
    #2 PRESET = 1'b1;
    #1;
    chk("async_rst_psel",    64'(PSEL), 64'd0);
    chk("async_rst_penable", 64'(PENABLE), 64'd0);
    chk("async_rst_busy",    64'(busy), 64'd0);
    req_valid = 2'b00;
    hang      = 1'b0;
    repeat (2) @(negedge PCLK);
    PRESET = 1'b0;
    contend(2);

    repeat (3) @(negedge PCLK);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/apb_arb_master.md
Name: apb_arb_master

Overview:
- Shares one APB slave port among NUM_REQ local requesters.
- Arbitrates round-robin and sequences the APB SETUP/ACCESS phases toward the slave.
- Returns read data, error and completion to the granted requester.
- Sits between bus-side clients and register slaves such as the reg0 APB slave. Adds a PREADY timeout so a hung slave cannot lock the bus.

Parameters:
- NUM_REQ, 2, number of requesters (>=2).
- ADDR_WIDTH, 32, APB address width.
- DATA_WIDTH, 32, APB data width.
- TIMEOUT, 16, max ACCESS cycles waiting for PREADY; 0 disables timeout.

Ports:
- PCLK  in  1  clock, rising edge.
- PRESET  in  1  reset.
- req_valid  in  NUM_REQ  per-requester request. Held high with stable payload until that requester's rsp_valid.
- req_write  in  NUM_REQ  per-requester direction, 1=write.
- req_addr  in  NUM_REQ*ADDR_WIDTH  flattened addresses; slice i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  NUM_REQ*DATA_WIDTH  flattened write data.
- rsp_valid  out  NUM_REQ  one-hot one-cycle completion pulse.
- rsp_rdata  out  DATA_WIDTH  read data, valid with rsp_valid.
- rsp_err  out  1  error (PSLVERR or timeout), valid with rsp_valid.
- grant  out  $clog2(NUM_REQ)  index of current/last granted requester.
- busy  out  1  high in SETUP, ACCESS and RESP.
- PSEL, PENABLE, PWRITE  out  1 each  APB control.
- PADDR  out  ADDR_WIDTH  APB address.
- PWDATA  out  DATA_WIDTH  APB write data.
- PRDATA  in  DATA_WIDTH  APB read data.
- PREADY, PSLVERR  in  1 each  APB response.

Behaviour:
- Interface: single clock PCLK; PRESET is asynchronous, active-high.
- Reset values: all outputs registered and 0. Internal state is IDLE, timeout counter 0, round-robin pointer last = NUM_REQ-1, so requester 0 wins first.
- States are IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - If any req_valid, pick the first set bit scanning from (last+1) mod NUM_REQ upward with wrap.
  - On that edge: latch the winner's write/addr/wdata into PWRITE/PADDR/PWDATA; set grant and last to the winner; PSEL=1, PENABLE=0; go to SETUP.
  - With no request, stay in IDLE with PSEL=0.
- SETUP: exactly one cycle. Next edge sets PENABLE=1; go to ACCESS.
- ACCESS:
  - PSEL=PENABLE=1. PADDR/PWRITE/PWDATA held stable. The counter increments each cycle PREADY=0.
  - PREADY=1: capture rsp_rdata = PRDATA on reads, 0 on writes; rsp_err = PSLVERR.
  - PREADY=0 and counter == TIMEOUT-1 with TIMEOUT>0: abort with rsp_rdata=0, rsp_err=1.
  - On either completion: PSEL=PENABLE=0, rsp_valid[grant]=1, clear the counter, go to RESP.
  - PREADY=1 in the same cycle the timeout would fire: PREADY wins, normal completion.
- RESP: one cycle, rsp_valid pulse high; no arbitration. The requester deasserts or changes its request by the edge ending RESP. Next edge clears rsp_valid; go to IDLE.
- Latency: request seen in IDLE at cycle 0 with zero-wait slave gives SETUP at cycle 1, ACCESS at cycle 2, rsp_valid at cycle 3, IDLE at cycle 4. Back-to-back transfers are 4 cycles each.
- Hold behaviour: rsp_rdata/rsp_err hold until the next completion. PADDR/PWRITE/PWDATA hold their last values in IDLE.
- Requests arriving mid-transfer wait; arbitration happens only in IDLE.
- A requester dropping req_valid before rsp_valid is a protocol violation. The transfer still completes and still pulses rsp_valid.
- PRESET mid-transfer: immediately IDLE, PSEL/PENABLE low, no rsp_valid for the aborted transfer, pointer reset.
- Unreachable state encoding goes to IDLE with outputs as in IDLE.

Decomposition:
- apb_pkg:
  - typedef apb_mst_state_t (IDLE, SETUP, ACCESS, RESP, 2-bit enum).
  - Constants APB_OKAY=1'b0, APB_ERR=1'b1.
- Sub-module rr_arbiter (parameter N):
  - Inputs req[N], last index.
  - Outputs valid and combinational winner index.
  - Instantiated once; the pointer register stays in apb_arb_master.

Test Plan (NUM_REQ=2, TIMEOUT=4, slave model with programmable wait states):
- Write, zero wait: req0 write addr 0x10 data 0xDEADBEEF. PSEL rises cycle 1, PENABLE cycle 2, slave register=0xDEADBEEF, rsp_valid=2'b01 at cycle 3, rsp_err=0.
- Read, 2 wait states: req1 read 0x10. ACCESS lasts 3 cycles, rsp_valid=2'b10 with rsp_rdata=0xDEADBEEF, PADDR stable throughout.
- Contention: both requesters hold req_valid from reset. Grants alternate 0,1,0,1 over 4 transfers; no transfer starts while busy.
- PSLVERR: slave returns PREADY=1, PSLVERR=1 on read. rsp_err=1, rsp_rdata=PRDATA, state back to IDLE.
- Timeout: slave never asserts PREADY. After 4 ACCESS cycles rsp_valid pulses with rsp_err=1, rsp_rdata=0; then PREADY=1 on exactly the 4th cycle gives normal completion, rsp_err=0.
- Reset: assert PRESET during ACCESS asynchronously. PSEL/PENABLE low with no clock edge, no rsp_valid; after release, requester 0 is granted first.
